// File: rtl/fir_decim_sequencer.sv
// fir_decim_sequencer
//   Initiator-side address/control sequencer for the polyphase decimator's
//   memory controller. Accepts samples over valid/ready, writes each into the
//   circular sample delay line, and after every D-th sample runs one MAC pass
//   of MAC_SIZE sample/coefficient reads. Emits the accumulate/clear/last
//   strobes one cycle behind the reads to match the RAM read latency.
//
// Ports
//   clk, rst          clock, async active-high reset
//   s_valid/s_ready   input sample handshake
//   c_we              external coefficient write in progress
//   sample_we/en/addr sample RAM control
//   coeff_en/addr     coefficient RAM read control
//   mac_clr/acc/last  MAC datapath strobes
//   busy              WRITE, COMPUTE or DRAIN active
//   coeff_collision   sticky: c_we seen during COMPUTE
//   phase             samples accepted since the last pass
module fir_decim_sequencer #(
  parameter  int MAC_SIZE = 255,
  parameter  int D        = 100,
  localparam int AW       = (MAC_SIZE > 1) ? $clog2(MAC_SIZE) : 1,
  localparam int PW       = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          c_we,
  output logic          sample_we,
  output logic          sample_en,
  output logic [AW-1:0] sample_addr,
  output logic          coeff_en,
  output logic [AW-1:0] coeff_addr,
  output logic          mac_clr,
  output logic          mac_acc,
  output logic          mac_last,
  output logic          busy,
  output logic          coeff_collision,
  output logic [PW-1:0] phase
);

  typedef enum logic [1:0] {IDLE, WRITE, COMPUTE, DRAIN} state_e;

  localparam logic [AW-1:0] ADDR_LAST  = AW'(MAC_SIZE - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(D - 1);

  state_e        state_q;
  logic [AW-1:0] ptr_q;      // newest sample slot
  logic [AW-1:0] k_q;        // tap index; doubles as the coeff read address
  logic [AW-1:0] saddr_q;
  logic [PW-1:0] phase_q;
  logic          s_ready_q, we_q, sen_q, cen_q;
  logic          clr_q, acc_q, last_q, busy_q, coll_q;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + AW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      k_q       <= '0;
      saddr_q   <= '0;
      phase_q   <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      sen_q     <= 1'b0;
      cen_q     <= 1'b0;
      clr_q     <= 1'b0;
      acc_q     <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      // single-cycle strobes default low; addresses hold
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      sen_q     <= 1'b0;
      cen_q     <= 1'b0;
      clr_q     <= 1'b0;
      acc_q     <= 1'b0;
      last_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid && s_ready_q) begin
            state_q <= WRITE;
            we_q    <= 1'b1;
            sen_q   <= 1'b1;
            saddr_q <= ptr_q;
            busy_q  <= 1'b1;
          end else begin
            s_ready_q <= !c_we;
          end
        end
        WRITE: begin
          if (phase_q == PHASE_LAST) begin
            // pass starts reading at the slot just written (k=0)
            state_q <= COMPUTE;
            phase_q <= '0;
            k_q     <= '0;
            saddr_q <= ptr_q;
            sen_q   <= 1'b1;
            cen_q   <= 1'b1;
          end else begin
            state_q   <= IDLE;
            phase_q   <= phase_q + PW'(1);
            ptr_q     <= wrap_inc(ptr_q);
            busy_q    <= 1'b0;
            s_ready_q <= !c_we;
          end
        end
        COMPUTE: begin
          if (c_we) coll_q <= 1'b1;
          // strobes describe the read issued this cycle, visible next cycle
          acc_q <= 1'b1;
          clr_q <= (k_q == '0);
          if (k_q == ADDR_LAST) begin
            state_q <= DRAIN;
            last_q  <= 1'b1;
          end else begin
            k_q     <= k_q + AW'(1);
            saddr_q <= (saddr_q == '0) ? ADDR_LAST : saddr_q - AW'(1);
            sen_q   <= 1'b1;
            cen_q   <= 1'b1;
          end
        end
        DRAIN: begin
          state_q   <= IDLE;
          ptr_q     <= wrap_inc(ptr_q);
          busy_q    <= 1'b0;
          s_ready_q <= !c_we;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready         = s_ready_q;
  assign sample_we       = we_q;
  assign sample_en       = sen_q;
  assign sample_addr     = saddr_q;
  assign coeff_en        = cen_q;
  assign coeff_addr      = k_q;
  assign mac_clr         = clr_q;
  assign mac_acc         = acc_q;
  assign mac_last        = last_q;
  assign busy            = busy_q;
  assign coeff_collision = coll_q;
  assign phase           = phase_q;

endmodule

// File: tb/tb_fir_decim_sequencer.sv
module tb_fir_decim_sequencer;
  localparam int M  = 4;
  localparam int D  = 3;
  localparam int AW = 2;
  localparam int PW = 2;

  logic          clk, rst, s_valid, c_we;
  logic          s_ready, sample_we, sample_en, coeff_en;
  logic          mac_clr, mac_acc, mac_last, busy, coeff_collision;
  logic [AW-1:0] sample_addr, coeff_addr;
  logic [PW-1:0] phase;

  fir_decim_sequencer #(.MAC_SIZE(M), .D(D)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .c_we(c_we),
    .sample_we(sample_we), .sample_en(sample_en), .sample_addr(sample_addr),
    .coeff_en(coeff_en), .coeff_addr(coeff_addr), .mac_clr(mac_clr),
    .mac_acc(mac_acc), .mac_last(mac_last), .busy(busy),
    .coeff_collision(coeff_collision), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected outputs for one clock cycle
  typedef struct {
    int we, en, addr, cen, caddr, acc, clr, last, busy, phase;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  int   m_ptr, m_phase;
  bit   m_ready, m_coll;
  int   nchk, nerr, last_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r = '{default: 0};
    r.phase = m_phase;
    return r;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ptr = 0; m_phase = 0; m_ready = 0; m_coll = 0;
    cur = idle_rec();
  endfunction

  // Advance the model across one rising edge using the inputs now driven.
  function automatic void model_step();
    rec_t r;
    if (cur.cen != 0 && c_we) m_coll = 1;
    if (s_valid && m_ready) begin
      r = '{default: 0};
      r.we = 1; r.en = 1; r.addr = m_ptr; r.busy = 1; r.phase = m_phase;
      q.push_back(r);
      if (m_phase == D - 1) begin
        m_phase = 0;
        for (int k = 0; k < M; k++) begin
          r = '{default: 0};
          r.en = 1; r.cen = 1; r.busy = 1;
          r.addr = (m_ptr - k + M) % M; r.caddr = k;
          r.acc = (k >= 1); r.clr = (k == 1);
          q.push_back(r);
        end
        r = '{default: 0};
        r.busy = 1; r.acc = 1; r.clr = (M == 1); r.last = 1;
        q.push_back(r);
      end else begin
        m_phase = m_phase + 1;
      end
      m_ptr = (m_ptr + 1) % M;
    end
    if (q.size() > 0) begin
      cur = q.pop_front();
      m_ready = 0;
    end else begin
      cur = idle_rec();
      m_ready = !c_we;
    end
  endfunction

  task automatic check_outputs();
    chk("s_ready", s_ready, m_ready);
    chk("sample_we", sample_we, cur.we);
    chk("sample_en", sample_en, cur.en);
    if (cur.en != 0) chk("sample_addr", sample_addr, cur.addr);
    chk("coeff_en", coeff_en, cur.cen);
    if (cur.cen != 0) chk("coeff_addr", coeff_addr, cur.caddr);
    chk("mac_acc", mac_acc, cur.acc);
    chk("mac_clr", mac_clr, cur.clr);
    chk("mac_last", mac_last, cur.last);
    chk("busy", busy, cur.busy);
    chk("collision", coeff_collision, m_coll);
    chk("phase", phase, cur.phase);
    if (mac_last) last_cnt++;
  endtask

  // check the current cycle, then drive inputs for the next edge
  task automatic cycle(input bit sv, input bit cw);
    @(negedge clk);
    check_outputs();
    s_valid = sv;
    c_we    = cw;
    if (!rst) model_step();
  endtask

  // caller has just raised rst; outputs must clear without a clock
  task automatic do_reset();
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_en", sample_en, 0);
    chk("rst_cen", coeff_en, 0);
    chk("rst_acc", mac_acc, 0);
    chk("rst_last", mac_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_coll", coeff_collision, 0);
    chk("rst_phase", phase, 0);
    model_reset();
    repeat (3) cycle(0, 0);
    rst = 1'b0;
    model_step();
  endtask

  task automatic run_until_k1(input string tag);
    int n = 0;
    while (!(cur.cen != 0 && cur.caddr == 1) && n < 100) begin
      cycle(1, 0);
      n++;
    end
    chk(tag, n < 100, 1);
  endtask

  initial begin
    nchk = 0; nerr = 0; last_cnt = 0;
    s_valid = 0; c_we = 0; rst = 1;
    do_reset();

    // stream 12+ samples back to back: 4 passes, ptr wraps inside a pass
    last_cnt = 0;
    repeat (46) cycle(1, 0);
    chk("passes_after_12", last_cnt, 4);
    repeat (4) cycle(0, 0);

    // coefficient write blocks acceptance while idle
    repeat (3) cycle(1, 1);
    repeat (3) cycle(1, 0);

    // coefficient write during the second compute cycle
    run_until_k1("wait_k1_coll");
    cycle(1, 1);
    repeat (10) cycle(1, 0);
    chk("coll_sticky", coeff_collision, 1);

    // reset in the middle of a pass
    run_until_k1("wait_k1_rst");
    @(posedge clk);
    #2 rst = 1'b1;
    do_reset();

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    repeat (8) cycle(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
